// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_pkg
//  Description : Shared opcode definitions for the pipelined ALU.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pipe_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    ERRFLG = 3'b000,
    BNE    = 3'b001,
    PAR    = 3'b010,
    ADD    = 3'b011,
    XOR    = 3'b100,
    LSOR   = 3'b101,
    RSVD6  = 3'b110,
    RSVD7  = 3'b111
  } op_mne;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational ALU datapath producing result and flags.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_mne            i_op,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zero,
  output logic             o_parity,
  output logic             o_carry
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-2:0] w_lsor;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Shift of the low W-1 bits drops the old bit W-2, keeping the result W-1 wide.
  assign w_lsor = {i_a[WIDTH-3:0], 1'b0} | i_b[WIDTH-2:0];

  // Result and carry/borrow selection; reserved opcodes fall through to zero.
  always_comb begin
    o_out   = '0;
    o_carry = 1'b0;
    case (i_op)
      ERRFLG: o_out = {^i_a, i_a[WIDTH-2:0]};
      BNE: begin
        o_out   = i_a - i_b;
        o_carry = (i_a < i_b);
      end
      PAR:    o_out = {{(WIDTH-1){1'b0}}, ^(i_a & i_b)};
      ADD: begin
        o_out   = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
      end
      XOR:    o_out = {1'b0, i_a[WIDTH-2:0] ^ i_b[WIDTH-2:0]};
      LSOR:   o_out = {1'b0, w_lsor};
      default: begin
        o_out   = '0;
        o_carry = 1'b0;
      end
    endcase
  end

  assign o_zero   = ~|o_out;
  assign o_parity = ^o_out;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready backpressure,
//                registered flags and sticky/saturating ERRFLG tracking.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic [OPW-1:0]   OP,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Parity,
  output logic             Carry,
  output logic             ErrSticky,
  output logic [CNTW-1:0]  ErrCnt,
  input  logic             ClrErr
);

  localparam logic [CNTW-1:0] c_cnt_max = '1;
  localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};

  // Stage 1 (operands) and stage 2 (result + flags)
  logic             r_v1;
  logic [WIDTH-1:0] r_a1;
  logic [WIDTH-1:0] r_b1;
  op_mne            r_op1;
  logic             r_v2;
  op_mne            r_op2;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_parity;
  logic             r_carry;
  logic             r_err_sticky;
  logic [CNTW-1:0]  r_err_cnt;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_accept;
  logic             w_consume;
  logic             w_err_hit;
  logic [WIDTH-1:0] w_core_out;
  logic             w_core_zero;
  logic             w_core_parity;
  logic             w_core_carry;

  // No skid buffer: upstream ready follows downstream ready combinationally.
  assign w_adv2    = !r_v2 || OutReady;
  assign w_adv1    = !r_v1 || w_adv2;
  assign w_accept  = InValid && w_adv1;
  assign w_consume = r_v2 && OutReady;
  assign w_err_hit = w_consume && (r_op2 == ERRFLG) && r_out[WIDTH-1];

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a      (r_a1),
    .i_b      (r_b1),
    .i_op     (r_op1),
    .o_out    (w_core_out),
    .o_zero   (w_core_zero),
    .o_parity (w_core_parity),
    .o_carry  (w_core_carry)
  );

  // Stage 1: capture operands and opcode on acceptance.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_v1  <= 1'b0;
      r_a1  <= '0;
      r_b1  <= '0;
      r_op1 <= ERRFLG;
    end else if (w_adv1) begin
      r_v1 <= InValid;
      if (w_accept) begin
        r_a1  <= InputA;
        r_b1  <= InputB;
        r_op1 <= op_mne'(OP);
      end
    end
  end

  // Stage 2: register result and flags; data held while stalled or emptying.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_v2     <= 1'b0;
      r_op2    <= ERRFLG;
      r_out    <= '0;
      r_zero   <= 1'b1;
      r_parity <= 1'b0;
      r_carry  <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_op2    <= r_op1;
        r_out    <= w_core_out;
        r_zero   <= w_core_zero;
        r_parity <= w_core_parity;
        r_carry  <= w_core_carry;
      end
    end
  end

  // Error tracking on consumed ERRFLG results; a new error beats a clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else if (w_err_hit) begin
      r_err_sticky <= 1'b1;
      if (ClrErr) begin
        r_err_cnt <= c_cnt_one;
      end else if (r_err_cnt != c_cnt_max) begin
        r_err_cnt <= r_err_cnt + c_cnt_one;
      end
    end else if (ClrErr) begin
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end
  end

  assign InReady   = w_adv1;
  assign OutValid  = r_v2;
  assign Out       = r_out;
  assign Zero      = r_zero;
  assign Parity    = r_parity;
  assign Carry     = r_carry;
  assign ErrSticky = r_err_sticky;
  assign ErrCnt    = r_err_cnt;

endmodule
`default_nettype wire
